// File: rtl/mram_access_ctrl.sv
// Single-access sequencer for an external parallel MRAM: accepts one read/write request,
// drives the active-low strobes with programmable setup/pulse/access/recovery timing.
module mram_access_ctrl #(
    parameter int T_SETUP = 1,
    parameter int T_WP    = 2,
    parameter int T_RD    = 3,
    parameter int T_REC   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [19:0] req_addr,
    input  logic [15:0] req_wdata,
    input  logic [1:0]  req_be,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        busy,
    output logic [19:0] mram_addr,
    output logic [15:0] mram_dq_out,
    output logic        mram_dq_oe,
    input  logic [15:0] mram_dq_in,
    output logic        chip_en,
    output logic        write_en,
    output logic        out_en,
    output logic        lower_byte_en,
    output logic        upper_byte_en
);

    localparam int T_MAX_A = (T_SETUP > T_WP) ? T_SETUP : T_WP;
    localparam int T_MAX_B = (T_RD > T_REC) ? T_RD : T_REC;
    localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
    localparam int CW      = $clog2(T_MAX) + 1;

    localparam logic [CW-1:0] SETUP_LD = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] WP_LD    = CW'(T_WP - 1);
    localparam logic [CW-1:0] RD_LD    = CW'(T_RD - 1);
    localparam logic [CW-1:0] REC_LD   = CW'(T_REC - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_WRITE,
        S_HOLD,
        S_READ,
        S_RECOVER
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          we_q;
    logic [1:0]    be_q;
    logic          req_ready_q;
    logic          busy_q;
    logic          rsp_valid_q;
    logic [15:0]   rsp_rdata_q;
    logic [19:0]   mram_addr_q;
    logic [15:0]   dq_out_q;
    logic          dq_oe_q;
    logic          chip_en_q;
    logic          write_en_q;
    logic          out_en_q;
    logic          lbe_q;
    logic          ube_q;

    // NOTE: every register, including the data/address holding registers, is cleared by the
    // async reset so the pins are in a defined, deselected state the instant rst falls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            be_q        <= 2'b00;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            mram_addr_q <= '0;
            dq_out_q    <= '0;
            dq_oe_q     <= 1'b0;
            chip_en_q   <= 1'b1;
            write_en_q  <= 1'b1;
            out_en_q    <= 1'b1;
            lbe_q       <= 1'b1;
            ube_q       <= 1'b1;
        end else begin
            // NOTE: non-blocking throughout; later assignments in a branch override the default.
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    req_ready_q <= 1'b1;
                    if (req_valid && req_ready_q) begin
                        state_q     <= S_SETUP;
                        cnt_q       <= SETUP_LD;
                        we_q        <= req_we;
                        be_q        <= req_be;
                        mram_addr_q <= req_addr;
                        chip_en_q   <= 1'b0;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (req_we) begin
                            dq_oe_q  <= 1'b1;
                            dq_out_q <= req_wdata;
                        end
                    end
                end

                S_SETUP: begin
                    if (cnt_q == '0) begin
                        lbe_q <= ~be_q[0];
                        ube_q <= ~be_q[1];
                        if (we_q) begin
                            state_q    <= S_WRITE;
                            cnt_q      <= WP_LD;
                            write_en_q <= 1'b0;
                        end else begin
                            state_q  <= S_READ;
                            cnt_q    <= RD_LD;
                            out_en_q <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end

                S_WRITE: begin
                    if (cnt_q == '0) begin
                        state_q    <= S_HOLD;
                        cnt_q      <= '0;
                        write_en_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end

                // Data, oe, chip enable and byte lanes stay put for one cycle after write_en rises.
                S_HOLD: begin
                    state_q     <= S_RECOVER;
                    cnt_q       <= REC_LD;
                    chip_en_q   <= 1'b1;
                    lbe_q       <= 1'b1;
                    ube_q       <= 1'b1;
                    dq_oe_q     <= 1'b0;
                    rsp_valid_q <= 1'b1;
                end

                S_READ: begin
                    if (cnt_q == '0) begin
                        rsp_rdata_q <= {be_q[1] ? mram_dq_in[15:8] : 8'h00,
                                        be_q[0] ? mram_dq_in[7:0]  : 8'h00};
                        state_q     <= S_RECOVER;
                        cnt_q       <= REC_LD;
                        chip_en_q   <= 1'b1;
                        out_en_q    <= 1'b1;
                        lbe_q       <= 1'b1;
                        ube_q       <= 1'b1;
                        rsp_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end

                S_RECOVER: begin
                    if (cnt_q == '0) begin
                        state_q     <= S_IDLE;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign req_ready     = req_ready_q;
    assign busy          = busy_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign mram_addr     = mram_addr_q;
    assign mram_dq_out   = dq_out_q;
    assign mram_dq_oe    = dq_oe_q;
    assign chip_en       = chip_en_q;
    assign write_en      = write_en_q;
    assign out_en        = out_en_q;
    assign lower_byte_en = lbe_q;
    assign upper_byte_en = ube_q;

endmodule

// File: tb/tb_mram_access_ctrl.sv
// Bench for mram_access_ctrl: two instances (default timing and a swept timing set) checked
// every cycle against a transaction-offset model, plus literal expectations for key scenarios.
module tb_mram_access_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req_valid [2];
    logic        req_we    [2];
    logic [19:0] req_addr  [2];
    logic [15:0] req_wdata [2];
    logic [1:0]  req_be    [2];
    logic        req_ready [2];
    logic        rsp_valid [2];
    logic [15:0] rsp_rdata [2];
    logic        busy      [2];
    logic [19:0] mram_addr [2];
    logic [15:0] dq_out    [2];
    logic        dq_oe     [2];
    logic [15:0] dq_in     [2];
    logic        chip_en   [2];
    logic        write_en  [2];
    logic        out_en    [2];
    logic        lbe       [2];
    logic        ube       [2];
    logic [15:0] rd_val    [2];

    // The memory only presents valid data while its output enable is low.
    assign dq_in[0] = (out_en[0] == 1'b0) ? rd_val[0] : 16'h5A5A;
    assign dq_in[1] = (out_en[1] == 1'b0) ? rd_val[1] : 16'h5A5A;

    mram_access_ctrl u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .busy(busy[0]),
        .mram_addr(mram_addr[0]), .mram_dq_out(dq_out[0]), .mram_dq_oe(dq_oe[0]),
        .mram_dq_in(dq_in[0]), .chip_en(chip_en[0]), .write_en(write_en[0]),
        .out_en(out_en[0]), .lower_byte_en(lbe[0]), .upper_byte_en(ube[0])
    );

    mram_access_ctrl #(.T_SETUP(3), .T_WP(4), .T_RD(1), .T_REC(2)) u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .busy(busy[1]),
        .mram_addr(mram_addr[1]), .mram_dq_out(dq_out[1]), .mram_dq_oe(dq_oe[1]),
        .mram_dq_in(dq_in[1]), .chip_en(chip_en[1]), .write_en(write_en[1]),
        .out_en(out_en[1]), .lower_byte_en(lbe[1]), .upper_byte_en(ube[1])
    );

    // Model state: k = cycles since the accepting edge (0 = idle).
    int          k        [2];
    int          since_rst[2];
    logic        m_we     [2];
    logic [1:0]  m_be     [2];
    logic [19:0] m_addr   [2];
    logic [15:0] m_dout   [2];
    logic [15:0] m_rdata  [2];
    int          hs_cnt   [2];
    int          hs_cyc   [2];
    int          wel      [2];
    int          oel      [2];
    int          lbl      [2];
    int          ubl      [2];
    int          rspn     [2];
    int          rsp_k    [2];
    int          cyc;
    int          n_cmp;
    int          n_bad;

    function automatic int p_ts(input int d);  return (d == 0) ? 1 : 3; endfunction
    function automatic int p_wp(input int d);  return (d == 0) ? 2 : 4; endfunction
    function automatic int p_rd(input int d);  return (d == 0) ? 3 : 1; endfunction
    function automatic int p_rec(input int d); return (d == 0) ? 1 : 2; endfunction

    function automatic int acc_len(input int d, input logic we);
        return we ? p_ts(d) + p_wp(d) + 1 + p_rec(d) : p_ts(d) + p_rd(d) + p_rec(d);
    endfunction

    function automatic logic [15:0] bmask(input logic [15:0] v, input logic [1:0] b);
        return {b[1] ? v[15:8] : 8'h00, b[0] ? v[7:0] : 8'h00};
    endfunction

    task automatic check(input string name, input int d, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h at t=%0t", name, d, act, exp, $time);
        end
    endtask

    task automatic model_reset(input int d);
        k[d]         = 0;
        since_rst[d] = 0;
        m_we[d]      = 1'b0;
        m_be[d]      = 2'b00;
        m_addr[d]    = '0;
        m_dout[d]    = '0;
        m_rdata[d]   = '0;
    endtask

    task automatic compare_cycle(input int d);
        int  ts, wp, rd, fr;
        bit  su, wr, hd, rdp, rec;
        ts  = p_ts(d);
        wp  = p_wp(d);
        rd  = p_rd(d);
        su  = (k[d] >= 1) && (k[d] <= ts);
        wr  = m_we[d] && (k[d] > ts) && (k[d] <= ts + wp);
        hd  = m_we[d] && (k[d] == ts + wp + 1);
        rdp = !m_we[d] && (k[d] > ts) && (k[d] <= ts + rd);
        fr  = m_we[d] ? ts + wp + 2 : ts + rd + 1;
        rec = (k[d] >= fr);
        check("req_ready", d, 32'(req_ready[d]), 32'((k[d] == 0) && (since_rst[d] > 0)));
        check("busy",      d, 32'(busy[d]),      32'(k[d] != 0));
        check("chip_en",   d, 32'(chip_en[d]),   32'(!(su || wr || hd || rdp)));
        check("write_en",  d, 32'(write_en[d]),  32'(!wr));
        check("out_en",    d, 32'(out_en[d]),    32'(!rdp));
        check("lower_be",  d, 32'(lbe[d]),       32'(!((wr || hd || rdp) && m_be[d][0])));
        check("upper_be",  d, 32'(ube[d]),       32'(!((wr || hd || rdp) && m_be[d][1])));
        check("dq_oe",     d, 32'(dq_oe[d]),     32'(m_we[d] && (su || wr || hd)));
        check("mram_addr", d, 32'(mram_addr[d]), 32'(m_addr[d]));
        check("dq_out",    d, 32'(dq_out[d]),    32'(m_dout[d]));
        check("rsp_valid", d, 32'(rsp_valid[d]), 32'(rec && (k[d] == fr)));
        check("rsp_rdata", d, 32'(rsp_rdata[d]), 32'(m_rdata[d]));
        check("inv_we_oe", d, 32'(!write_en[d] && !out_en[d]), 32'(0));
        check("inv_oe_bus", d, 32'(dq_oe[d] && !out_en[d]), 32'(0));
        if (write_en[d] == 1'b0) wel[d]++;
        if (out_en[d] == 1'b0)   oel[d]++;
        if (lbe[d] == 1'b0)      lbl[d]++;
        if (ube[d] == 1'b0)      ubl[d]++;
        if (rsp_valid[d] == 1'b1) begin
            rspn[d]++;
            rsp_k[d] = k[d];
        end
    endtask

    task automatic advance(input int d);
        if (!rst) begin
            model_reset(d);
            return;
        end
        if (k[d] == 0) begin
            if (since_rst[d] > 0 && req_valid[d]) begin
                m_we[d]   = req_we[d];
                m_be[d]   = req_be[d];
                m_addr[d] = req_addr[d];
                if (req_we[d]) m_dout[d] = req_wdata[d];
                k[d]      = 1;
                hs_cnt[d]++;
                hs_cyc[d] = cyc;
            end
        end else begin
            if (!m_we[d] && k[d] == p_ts(d) + p_rd(d)) m_rdata[d] = bmask(rd_val[d], m_be[d]);
            if (k[d] == acc_len(d, m_we[d])) k[d] = 0;
            else k[d]++;
        end
        since_rst[d]++;
    endtask

    task automatic step();
        @(negedge clk);
        for (int d = 0; d < 2; d++) compare_cycle(d);
        for (int d = 0; d < 2; d++) advance(d);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats(input int d);
        wel[d]   = 0;
        oel[d]   = 0;
        lbl[d]   = 0;
        ubl[d]   = 0;
        rspn[d]  = 0;
        rsp_k[d] = -1;
    endtask

    task automatic access(input int d, input logic we, input logic [19:0] a,
                          input logic [15:0] wd, input logic [1:0] be,
                          input logic [15:0] rv, input bit keep, input bit toggle);
        int h0;
        int n;
        logic [31:0] r;
        h0 = hs_cnt[d];
        n  = 0;
        req_we[d]    = we;
        req_addr[d]  = a;
        req_wdata[d] = wd;
        req_be[d]    = be;
        rd_val[d]    = rv;
        req_valid[d] = 1'b1;
        clear_stats(d);
        while (hs_cnt[d] == h0 && n < 40) begin
            step();
            n++;
        end
        check("handshake", d, 32'(hs_cnt[d] - h0), 32'(1));
        if (!keep) req_valid[d] = 1'b0;
        n = 0;
        while (k[d] != 0 && n < 40) begin
            if (toggle && !keep) begin
                r = $urandom;
                req_addr[d]  = r[19:0];
                req_be[d]    = r[21:20];
                req_we[d]    = r[22];
                r = $urandom;
                req_wdata[d] = r[15:0];
            end
            step();
            n++;
        end
        check("access_done", d, 32'(k[d]), 32'(0));
    endtask

    initial begin
        int c0;
        logic [31:0] r1, r2;
        n_cmp = 0;
        n_bad = 0;
        cyc   = 0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0;
            req_we[d]    = 1'b0;
            req_addr[d]  = '0;
            req_wdata[d] = '0;
            req_be[d]    = 2'b00;
            rd_val[d]    = '0;
            hs_cnt[d]    = 0;
            hs_cyc[d]    = 0;
            model_reset(d);
            clear_stats(d);
        end
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        repeat (3) step();
        check("ready_after_reset", 0, 32'(req_ready[0]), 32'(1));

        // Full write, then full read, default timing.
        access(0, 1'b1, 20'hABCDE, 16'h1234, 2'b11, 16'h0000, 1'b0, 1'b1);
        check("wr_we_width",  0, 32'(wel[0]), 32'(2));
        check("wr_rsp_cycle", 0, 32'(rsp_k[0]), 32'(5));
        check("wr_rsp_count", 0, 32'(rspn[0]), 32'(1));
        check("wr_addr_pin",  0, 32'(mram_addr[0]), 32'h000ABCDE);
        check("wr_data_pin",  0, 32'(dq_out[0]), 32'h00001234);
        repeat (2) step();

        access(0, 1'b0, 20'h00010, 16'h0000, 2'b11, 16'hBEEF, 1'b0, 1'b1);
        check("rd_oe_width",  0, 32'(oel[0]), 32'(3));
        check("rd_rsp_cycle", 0, 32'(rsp_k[0]), 32'(5));
        check("rd_data",      0, 32'(rsp_rdata[0]), 32'h0000BEEF);
        repeat (2) step();

        // Byte lanes.
        access(0, 1'b0, 20'h00020, 16'h0000, 2'b01, 16'hBEEF, 1'b0, 1'b1);
        check("rd_lo_data",   0, 32'(rsp_rdata[0]), 32'h000000EF);
        check("rd_lo_lower",  0, 32'(lbl[0]), 32'(3));
        check("rd_lo_upper",  0, 32'(ubl[0]), 32'(0));
        repeat (1) step();
        access(0, 1'b1, 20'h00030, 16'hC3A5, 2'b10, 16'h0000, 1'b0, 1'b1);
        check("wr_hi_lower",  0, 32'(lbl[0]), 32'(0));
        check("wr_hi_upper",  0, 32'(ubl[0]), 32'(3));
        check("wr_keeps_rd",  0, 32'(rsp_rdata[0]), 32'h000000EF);
        repeat (2) step();

        // Back-to-back with req_valid held high.
        access(0, 1'b1, 20'h11111, 16'h2222, 2'b11, 16'h0000, 1'b1, 1'b0);
        c0 = hs_cyc[0];
        access(0, 1'b0, 20'h33333, 16'h0000, 2'b11, 16'h4444, 1'b0, 1'b1);
        check("b2b_gap",      0, 32'(hs_cyc[0] - c0), 32'(6));
        check("b2b_rd_data",  0, 32'(rsp_rdata[0]), 32'h00004444);
        repeat (2) step();

        // Reset in the middle of the write pulse.
        req_we[0] = 1'b1; req_addr[0] = 20'h55555; req_wdata[0] = 16'h6666; req_be[0] = 2'b11;
        req_valid[0] = 1'b1;
        c0 = hs_cnt[0];
        for (int n = 0; n < 20 && hs_cnt[0] == c0; n++) step();
        req_valid[0] = 1'b0;
        for (int n = 0; n < 20 && k[0] != 2; n++) step();
        check("pre_rst_we",   0, 32'(write_en[0]), 32'(0));
        #2 rst = 1'b0;
        #1;
        check("rst_we",       0, 32'(write_en[0]), 32'(1));
        check("rst_ce",       0, 32'(chip_en[0]), 32'(1));
        check("rst_oe",       0, 32'(dq_oe[0]), 32'(0));
        model_reset(0);
        model_reset(1);
        clear_stats(0);
        repeat (2) step();
        rst = 1'b1;
        repeat (8) step();
        check("rst_no_rsp",   0, 32'(rspn[0]), 32'(0));
        check("rst_ready",    0, 32'(req_ready[0]), 32'(1));

        // Swept timing instance.
        access(1, 1'b1, 20'h0F0F0, 16'hA55A, 2'b11, 16'h0000, 1'b0, 1'b1);
        check("sw_we_width",  1, 32'(wel[1]), 32'(4));
        check("sw_rsp_cycle", 1, 32'(rsp_k[1]), 32'(9));
        repeat (1) step();
        access(1, 1'b0, 20'h0F0F1, 16'h0000, 2'b11, 16'h9876, 1'b0, 1'b1);
        check("sw_oe_width",  1, 32'(oel[1]), 32'(1));
        check("sw_rd_data",   1, 32'(rsp_rdata[1]), 32'h00009876);
        repeat (1) step();
        access(1, 1'b0, 20'h0F0F2, 16'h0000, 2'b00, 16'hBEEF, 1'b0, 1'b1);
        check("sw_be0_data",  1, 32'(rsp_rdata[1]), 32'h00000000);
        check("sw_be0_rsp",   1, 32'(rspn[1]), 32'(1));
        check("sw_be0_lanes", 1, 32'(lbl[1] + ubl[1]), 32'(0));

        // Randomized traffic on both instances.
        for (int t = 0; t < 60; t++) begin
            r1 = $urandom;
            r2 = $urandom;
            access(int'(r1[0]), r1[1], r2[19:0], r1[31:16], r1[3:2], r2[31:16], r1[4], r1[5]);
            repeat (int'(r1[7:6])) step();
        end
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b0;
        repeat (25) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
